// File: rtl/kf_ctrl_pkg.sv
// Shared types and defaults for the Kalman frame controller.
// Holds the FSM state enum, the sensor index enum, the default I2C addresses,
// the sample geometry and the address decode helper.
package kf_ctrl_pkg;

  localparam logic [6:0] DEF_ACC_ADDR  = 7'h78;
  localparam logic [6:0] DEF_GYRO_ADDR = 7'h79;
  localparam logic [6:0] DEF_MAG_ADDR  = 7'h7A;
  localparam int         DEF_NBYTES    = 6;
  localparam int         SAMPLE_W      = 48;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    PUBLISH = 2'd3
  } kf_state_e;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    GYRO = 2'd1,
    MAG  = 2'd2,
    NONE = 2'd3
  } sensor_e;

  // Map a received 7-bit I2C address onto a sensor slot; anything else is NONE.
  function automatic sensor_e decode_addr(input logic [6:0] a,
                                          input logic [6:0] acc_a,
                                          input logic [6:0] gyro_a,
                                          input logic [6:0] mag_a);
    if (a == acc_a)  return ACC;
    if (a == gyro_a) return GYRO;
    if (a == mag_a)  return MAG;
    return NONE;
  endfunction

endpackage

// File: rtl/kf_byte_assembler.sv
// Byte assembler: decodes the I2C address, shifts MSB-first bytes into the
// staging register of the addressed sensor, and commits a sample (valid bit)
// when a transfer ends with exactly NBYTES bytes.
// len_err / ovr_err are registered one-cycle pulses.
// Event order inside one cycle: address, then byte, then transfer end.
// snap_clr clears every valid bit except one committed in the same cycle;
// a commit that coincides with snap_clr is not an overrun because the older
// sample is being consumed on that very edge.
module kf_byte_assembler
  import kf_ctrl_pkg::*;
#(
  parameter logic [6:0] ACC_ADDR  = DEF_ACC_ADDR,
  parameter logic [6:0] GYRO_ADDR = DEF_GYRO_ADDR,
  parameter logic [6:0] MAG_ADDR  = DEF_MAG_ADDR,
  parameter int         NBYTES    = DEF_NBYTES
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  addr_valid,
  input  logic [6:0]            addr,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  input  logic                  xfer_end,
  input  logic                  snap_clr,
  output logic [2:0]            valid,
  output logic [NBYTES*8-1:0]   stg_acc,
  output logic [NBYTES*8-1:0]   stg_gyro,
  output logic [NBYTES*8-1:0]   stg_mag,
  output logic                  len_err,
  output logic                  ovr_err
);

  localparam int SW = NBYTES * 8;
  localparam int CW = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] FULL = CW'(NBYTES);

  sensor_e         act_q, act_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            over_q, over_d;
  logic [SW-1:0]   stg_q [3];
  logic [SW-1:0]   stg_d [3];
  logic [2:0]      valid_q, valid_d;
  logic            len_err_q, len_err_d;
  logic            ovr_err_q, ovr_err_d;

  // Next-state for decode, byte shifting, commit and error detection.
  always_comb begin
    act_d     = act_q;
    cnt_d     = cnt_q;
    over_d    = over_q;
    stg_d     = stg_q;
    valid_d   = valid_q;
    len_err_d = 1'b0;
    ovr_err_d = 1'b0;

    if (addr_valid) begin
      // A new address while a transfer is only partly received drops it.
      if (act_q != NONE && cnt_q != '0 && cnt_q < FULL) len_err_d = 1'b1;
      act_d  = decode_addr(addr, ACC_ADDR, GYRO_ADDR, MAG_ADDR);
      cnt_d  = '0;
      over_d = 1'b0;
    end

    if (byte_valid && act_d != NONE) begin
      stg_d[act_d] = {stg_d[act_d][SW-9:0], byte_data};
      if (cnt_d == FULL) over_d = 1'b1;
      else               cnt_d  = cnt_d + CW'(1);
    end

    if (snap_clr) valid_d = 3'b000;

    if (xfer_end) begin
      if (act_d != NONE) begin
        if (cnt_d == FULL && !over_d) begin
          if (valid_q[act_d] && !snap_clr) ovr_err_d = 1'b1;
          valid_d[act_d] = 1'b1;
        end else begin
          len_err_d = 1'b1;
        end
      end
      act_d  = NONE;
      cnt_d  = '0;
      over_d = 1'b0;
    end
  end

  // Assembler state registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      act_q     <= NONE;
      cnt_q     <= '0;
      over_q    <= 1'b0;
      stg_q     <= '{default: '0};
      valid_q   <= 3'b000;
      len_err_q <= 1'b0;
      ovr_err_q <= 1'b0;
    end else begin
      act_q     <= act_d;
      cnt_q     <= cnt_d;
      over_q    <= over_d;
      stg_q     <= stg_d;
      valid_q   <= valid_d;
      len_err_q <= len_err_d;
      ovr_err_q <= ovr_err_d;
    end
  end

  assign valid    = valid_q;
  assign stg_acc  = stg_q[0];
  assign stg_gyro = stg_q[1];
  assign stg_mag  = stg_q[2];
  assign len_err  = len_err_q;
  assign ovr_err  = ovr_err_q;

endmodule

// File: rtl/kf_frame_ctrl.sv
// Kalman frame controller top.
// Collects three sensor samples through kf_byte_assembler, snapshots them once
// all are fresh, launches one filter iteration (kf_start / kf_done) and hands
// the result to the SPI buffer (res_load / res_ready).
// Optional macro KF_TIMEOUT_EN adds a kf_done watchdog of TIMEOUT_CYC cycles;
// without it WAIT holds indefinitely and to_err is tied to 0.
// Handshake: res_load stays high in PUBLISH and the transfer happens on the
// rising edge where res_load and res_ready are both 1.
module kf_frame_ctrl
  import kf_ctrl_pkg::*;
#(
  parameter logic [6:0] ACC_ADDR    = DEF_ACC_ADDR,
  parameter logic [6:0] GYRO_ADDR   = DEF_GYRO_ADDR,
  parameter logic [6:0] MAG_ADDR    = DEF_MAG_ADDR,
  parameter int         NBYTES      = DEF_NBYTES,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  addr_valid,
  input  logic [6:0]            addr,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  input  logic                  xfer_end,
  output logic                  kf_start,
  input  logic                  kf_done,
  output logic [NBYTES*8-1:0]   acc_out,
  output logic [NBYTES*8-1:0]   gyro_out,
  output logic [NBYTES*8-1:0]   mag_out,
  output logic                  res_load,
  input  logic                  res_ready,
  output logic                  len_err,
  output logic                  ovr_err,
  output logic                  to_err,
  output logic [15:0]           frame_cnt,
  output kf_state_e             dbg_state
);

  localparam int SW = NBYTES * 8;

  kf_state_e     state_q, state_d;
  logic [2:0]    valid;
  logic [SW-1:0] stg_acc, stg_gyro, stg_mag;
  logic [SW-1:0] acc_q, gyro_q, mag_q;
  logic [15:0]   frame_cnt_q;
  logic          snap;
  logic          publish;

  kf_byte_assembler #(
    .ACC_ADDR  (ACC_ADDR),
    .GYRO_ADDR (GYRO_ADDR),
    .MAG_ADDR  (MAG_ADDR),
    .NBYTES    (NBYTES)
  ) u_asm (
    .clk        (clk),
    .n_rst      (n_rst),
    .addr_valid (addr_valid),
    .addr       (addr),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .xfer_end   (xfer_end),
    .snap_clr   (snap),
    .valid      (valid),
    .stg_acc    (stg_acc),
    .stg_gyro   (stg_gyro),
    .stg_mag    (stg_mag),
    .len_err    (len_err),
    .ovr_err    (ovr_err)
  );

`ifdef KF_TIMEOUT_EN
  localparam logic [12:0] WD_LIMIT = 13'(TIMEOUT_CYC - 1);
  logic [12:0] wd_q, wd_d;
  logic        timeout;
  logic        to_err_q;
`endif

  // Next-state and decoded outputs of the frame sequencer.
  always_comb begin
    state_d  = state_q;
    snap     = 1'b0;
    publish  = 1'b0;
    kf_start = 1'b0;
    res_load = 1'b0;
`ifdef KF_TIMEOUT_EN
    timeout  = 1'b0;
`endif
    case (state_q)
      COLLECT: begin
        if (valid == 3'b111) begin
          state_d = LAUNCH;
          snap    = 1'b1;
        end
      end
      LAUNCH: begin
        kf_start = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (kf_done) begin
          state_d = PUBLISH;
        end
`ifdef KF_TIMEOUT_EN
        else if (wd_q == WD_LIMIT) begin
          timeout = 1'b1;
          state_d = COLLECT;
        end
`endif
      end
      PUBLISH: begin
        res_load = 1'b1;
        if (res_ready) begin
          state_d = COLLECT;
          publish = 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= COLLECT;
    else        state_q <= state_d;
  end

  // Operand snapshot: held from launch until the next launch.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc_q  <= '0;
      gyro_q <= '0;
      mag_q  <= '0;
    end else if (snap) begin
      acc_q  <= stg_acc;
      gyro_q <= stg_gyro;
      mag_q  <= stg_mag;
    end
  end

  // Published-frame counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)       frame_cnt_q <= 16'd0;
    else if (publish) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

`ifdef KF_TIMEOUT_EN
  // Watchdog counts cycles spent in WAIT; it is zero on the first WAIT cycle.
  always_comb begin
    wd_d = (state_q == WAIT) ? wd_q + 13'd1 : 13'd0;
  end

  // Watchdog counter and registered timeout pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wd_q     <= 13'd0;
      to_err_q <= 1'b0;
    end else begin
      wd_q     <= wd_d;
      to_err_q <= timeout;
    end
  end

  assign to_err = to_err_q;
`else
  assign to_err = 1'b0;
`endif

  assign acc_out   = acc_q;
  assign gyro_out  = gyro_q;
  assign mag_out   = mag_q;
  assign frame_cnt = frame_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_kf_frame_ctrl.sv
// Bench for kf_frame_ctrl (default build, KF_TIMEOUT_EN undefined).
// A behavioural model tracks sensor transfers and frame progress in plain
// variables; launched operand triples go through exp_q and are taken out on
// the cycle kf_start is due. Every cycle the model is compared with the DUT.
module tb_kf_frame_ctrl;
  import kf_ctrl_pkg::*;

  localparam int NB = 6;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        addr_valid = 1'b0;
  logic [6:0]  addr = 7'h00;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        xfer_end = 1'b0;
  logic        kf_done = 1'b0;
  logic        res_ready = 1'b0;
  logic        kf_start, res_load, len_err, ovr_err, to_err;
  logic [47:0] acc_out, gyro_out, mag_out;
  logic [15:0] frame_cnt;
  kf_state_e   dbg_state;

  int checks = 0;
  int errors = 0;
  bit rand_resp = 1'b0;

  // model state
  logic [47:0] m_stg [3];
  bit          m_valid [3];
  int          m_act;
  int          m_cnt;
  bit          m_over;
  bit          m_len, m_ovr;
  logic [47:0] m_snap [3];
  bit          f_open, f_done;
  longint      cyc, f_start_cyc;
  logic [15:0] m_frames;
  logic [47:0] exp_q [$];

  kf_frame_ctrl dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .addr_valid (addr_valid),
    .addr       (addr),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .xfer_end   (xfer_end),
    .kf_start   (kf_start),
    .kf_done    (kf_done),
    .acc_out    (acc_out),
    .gyro_out   (gyro_out),
    .mag_out    (mag_out),
    .res_load   (res_load),
    .res_ready  (res_ready),
    .len_err    (len_err),
    .ovr_err    (ovr_err),
    .to_err     (to_err),
    .frame_cnt  (frame_cnt),
    .dbg_state  (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dec(input logic [6:0] a);
    case (a)
      7'h78:   return 0;
      7'h79:   return 1;
      7'h7A:   return 2;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_stg[i] = '0; m_valid[i] = 1'b0; m_snap[i] = '0;
    end
    m_act = -1; m_cnt = 0; m_over = 1'b0; m_len = 1'b0; m_ovr = 1'b0;
    f_open = 1'b0; f_done = 1'b0; cyc = 0; f_start_cyc = 0; m_frames = 16'd0;
    exp_q.delete();
  endtask

  // Compare the current cycle, then advance the model with the inputs that
  // will be sampled at the coming rising edge.
  task automatic model_cycle();
    bit e_start, launch, nlen, novr;
    bit old_v [3];
    if (!n_rst) begin
      model_reset();
      return;
    end
    e_start = f_open && (cyc == f_start_cyc);
    if (e_start) begin
      if (exp_q.size() >= 3) begin
        m_snap[0] = exp_q.pop_front();
        m_snap[1] = exp_q.pop_front();
        m_snap[2] = exp_q.pop_front();
      end else begin
        chk("exp_q_underflow", 64'(exp_q.size()), 64'd3);
      end
    end
    chk("kf_start", kf_start, e_start);
    chk("res_load", res_load, f_open && f_done);
    chk("len_err", len_err, m_len);
    chk("ovr_err", ovr_err, m_ovr);
    chk("to_err", to_err, 1'b0);
    chk("acc_out", acc_out, m_snap[0]);
    chk("gyro_out", gyro_out, m_snap[1]);
    chk("mag_out", mag_out, m_snap[2]);
    chk("frame_cnt", frame_cnt, m_frames);

    // frame progress
    launch = !f_open && m_valid[0] && m_valid[1] && m_valid[2];
    if (launch) begin
      exp_q.push_back(m_stg[0]);
      exp_q.push_back(m_stg[1]);
      exp_q.push_back(m_stg[2]);
      f_open = 1'b1; f_done = 1'b0; f_start_cyc = cyc + 1;
    end else if (f_open) begin
      if (f_done) begin
        if (res_ready) begin f_open = 1'b0; m_frames = m_frames + 16'd1; end
      end else if (cyc > f_start_cyc && kf_done) begin
        f_done = 1'b1;
      end
    end

    // sensor transfers: address, then byte, then end
    nlen = 1'b0; novr = 1'b0;
    for (int i = 0; i < 3; i++) old_v[i] = m_valid[i];
    if (addr_valid) begin
      if (m_act >= 0 && m_cnt > 0 && m_cnt < NB) nlen = 1'b1;
      m_act = dec(addr); m_cnt = 0; m_over = 1'b0;
    end
    if (byte_valid && m_act >= 0) begin
      m_stg[m_act] = (m_stg[m_act] << 8) | 48'(byte_data);
      if (m_cnt == NB) m_over = 1'b1;
      else             m_cnt++;
    end
    if (launch) for (int i = 0; i < 3; i++) m_valid[i] = 1'b0;
    if (xfer_end) begin
      if (m_act >= 0) begin
        if (m_cnt == NB && !m_over) begin
          if (old_v[m_act] && !launch) novr = 1'b1;
          m_valid[m_act] = 1'b1;
        end else begin
          nlen = 1'b1;
        end
      end
      m_act = -1; m_cnt = 0; m_over = 1'b0;
    end
    m_len = nlen; m_ovr = novr;
    cyc++;
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // One clock cycle: check/advance at the falling edge, drive after the rise.
  task automatic step();
    @(negedge clk);
    model_cycle();
    if (errors > 40) finish_run();
    @(posedge clk);
    #1;
    if (rand_resp) begin
      kf_done   = ($urandom_range(0, 7) == 0);
      res_ready = $urandom_range(0, 1) != 0;
    end
  endtask

  // driver tasks
  task automatic send_addr(input logic [6:0] a);
    addr = a; addr_valid = 1'b1; step(); addr_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_data = b; byte_valid = 1'b1; step(); byte_valid = 1'b0;
  endtask

  task automatic send_end();
    xfer_end = 1'b1; step(); xfer_end = 1'b0;
  endtask

  task automatic send_xfer(input logic [6:0] a, input int n, input logic [7:0] first, input int incr);
    send_addr(a);
    for (int i = 0; i < n; i++) send_byte(first + 8'(i * incr));
    send_end();
  endtask

  initial begin
    model_reset();
    repeat (3) step();
    chk("rst_kf_start", kf_start, 1'b0);
    chk("rst_res_load", res_load, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 16'd0);
    chk("rst_acc_out", acc_out, 48'h0);
    chk("rst_len_err", len_err, 1'b0);
    n_rst = 1'b1;
    step();

    // nominal frame
    res_ready = 1'b1;
    send_xfer(7'h78, 6, 8'h01, 1);
    send_xfer(7'h79, 6, 8'h11, 1);
    send_xfer(7'h7A, 6, 8'h21, 1);
    chk("nom_start_early", kf_start, 1'b0);
    step();
    chk("nom_start", kf_start, 1'b1);
    chk("nom_acc", acc_out, 48'h010203040506);
    chk("nom_gyro", gyro_out, 48'h111213141516);
    chk("nom_mag", mag_out, 48'h212223242526);
    step();
    chk("nom_start_once", kf_start, 1'b0);
    kf_done = 1'b1; step(); kf_done = 1'b0;
    chk("nom_res_load", res_load, 1'b1);
    step();
    chk("nom_res_load_off", res_load, 1'b0);
    chk("nom_frame_cnt", frame_cnt, 16'd1);

    // short and long transfers
    send_xfer(7'h78, 5, 8'h61, 1);
    chk("short_len_err", len_err, 1'b1);
    step();
    chk("short_len_err_pulse", len_err, 1'b0);
    send_xfer(7'h78, 7, 8'h71, 1);
    chk("long_len_err", len_err, 1'b1);

    // overrun on gyro
    send_xfer(7'h79, 6, 8'hAA, 0);
    chk("ovr_first", ovr_err, 1'b0);
    send_xfer(7'h79, 6, 8'hBB, 0);
    chk("ovr_second", ovr_err, 1'b1);
    send_xfer(7'h50, 6, 8'h01, 1);
    chk("unk_len_err", len_err, 1'b0);
    chk("unk_ovr_err", ovr_err, 1'b0);
    send_xfer(7'h78, 6, 8'h41, 1);
    send_xfer(7'h7A, 6, 8'h51, 1);
    step();
    chk("ovr_start", kf_start, 1'b1);
    chk("ovr_gyro", gyro_out, 48'hBBBBBBBBBBBB);
    chk("ovr_acc", acc_out, 48'h414243444546);
    step();

    // collection while waiting leaves the snapshot alone
    send_xfer(7'h78, 6, 8'h31, 1);
    chk("wait_acc_hold", acc_out, 48'h414243444546);

    // backpressure on the result buffer
    res_ready = 1'b0;
    kf_done = 1'b1; step(); kf_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_res_load", res_load, 1'b1);
      chk("bp_frame_cnt", frame_cnt, 16'd1);
      step();
    end
    res_ready = 1'b1;
    chk("bp_res_load_last", res_load, 1'b1);
    step();
    chk("bp_frame_cnt_after", frame_cnt, 16'd2);
    chk("bp_res_load_off", res_load, 1'b0);

    // next frame uses the ACC sample collected during WAIT
    send_xfer(7'h79, 6, 8'h61, 1);
    send_xfer(7'h7A, 6, 8'h71, 1);
    step();
    chk("f3_start", kf_start, 1'b1);
    chk("f3_acc", acc_out, 48'h313233343536);
    step();

    // asynchronous reset in WAIT
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_kf_start", kf_start, 1'b0);
    chk("arst_acc", acc_out, 48'h0);
    chk("arst_gyro", gyro_out, 48'h0);
    chk("arst_mag", mag_out, 48'h0);
    chk("arst_frame_cnt", frame_cnt, 16'd0);
    chk("arst_res_load", res_load, 1'b0);
    step();
    step();
    n_rst = 1'b1;
    step();

    // WAIT holds without kf_done
    res_ready = 1'b1;
    send_xfer(7'h78, 6, 8'h81, 1);
    send_xfer(7'h79, 6, 8'h91, 1);
    send_xfer(7'h7A, 6, 8'hA1, 1);
    step();
    chk("hold_start", kf_start, 1'b1);
    repeat (10000) step();
    chk("hold_res_load", res_load, 1'b0);
    chk("hold_frame_cnt", frame_cnt, 16'd0);
    kf_done = 1'b1; step(); kf_done = 1'b0;
    step();
    chk("hold_release_cnt", frame_cnt, 16'd1);

    // randomized traffic with random core/buffer responses
    rand_resp = 1'b1;
    for (int t = 0; t < 900; t++) begin
      int r, n, e;
      logic [6:0] a;
      r = $urandom_range(0, 9);
      a = (r < 3) ? 7'h78 : (r < 6) ? 7'h79 : (r < 9) ? 7'h7A : 7'h50;
      n = ($urandom_range(0, 9) < 7) ? 6 : $urandom_range(4, 8);
      e = $urandom_range(0, 9);
      send_addr(a);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) step();
        byte_data = 8'($urandom_range(0, 255));
        byte_valid = 1'b1;
        if (i == n - 1 && e == 1) xfer_end = 1'b1;
        step();
        byte_valid = 1'b0;
        xfer_end = 1'b0;
      end
      if (e >= 2) begin
        repeat ($urandom_range(0, 1)) step();
        send_end();
      end
      repeat ($urandom_range(0, 4)) step();
    end
    rand_resp = 1'b0;
    kf_done = 1'b0;
    res_ready = 1'b1;
    repeat (50) step();
    finish_run();
  end

endmodule
